// File: rtl/ram_rd_check.sv
// Read-back checker for the dual-port RAM exercise: it compares every read word
// against its own address, accounting for RAM read latency, and reports per round.
module ram_rd_check #(
  parameter int ADDR_W          = 5,
  parameter int DATA_W          = 8,
  parameter int RD_LATENCY      = 1,
  parameter int READS_PER_ROUND = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ram_en_a,
  input  logic              ram_en_b,
  input  logic              ram_we_a,
  input  logic              ram_we_b,
  input  logic [ADDR_W-1:0] ram_addr_a,
  input  logic [ADDR_W-1:0] ram_addr_b,
  input  logic [DATA_W-1:0] ram_rd_data_a,
  input  logic [DATA_W-1:0] ram_rd_data_b,
  output logic              chk_done,
  output logic              round_ok,
  output logic              err_flag,
  output logic [15:0]       err_cnt_a,
  output logic [15:0]       err_cnt_b,
  output logic [15:0]       round_cnt,
  output logic              first_err_port,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_REPORT
  } state_t;

  state_t state, state_nxt;

  // Port 0 is A, port 1 is B throughout.
  logic [1:0]        smp;
  logic [ADDR_W-1:0] addr_in [2];
  logic [DATA_W-1:0] data_in [2];

  assign smp        = {ram_en_b & ~ram_we_b, ram_en_a & ~ram_we_a};
  assign addr_in[0] = ram_addr_a;
  assign addr_in[1] = ram_addr_b;
  assign data_in[0] = ram_rd_data_a;
  assign data_in[1] = ram_rd_data_b;

  logic [RD_LATENCY-1:0] vld [2];
  logic [ADDR_W-1:0]     adr [2][RD_LATENCY];

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld[0] <= '0;
      vld[1] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        vld[p][0] <= smp[p];
        for (int i = 1; i < RD_LATENCY; i++) vld[p][i] <= vld[p][i-1];
      end
    end
  end

  // NOTE: the address pipe needs no reset; its valid bit gates every use of it.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      adr[p][0] <= addr_in[p];
      for (int i = 1; i < RD_LATENCY; i++) adr[p][i] <= adr[p][i-1];
    end
  end

  logic [1:0]        cmp, mis;
  logic [DATA_W-1:0] exp_w [2];

  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    cmp = '0;
    mis = '0;
    for (int p = 0; p < 2; p++) begin
      exp_w[p] = DATA_W'(adr[p][RD_LATENCY-1]);
      cmp[p]   = vld[p][RD_LATENCY-1];
      mis[p]   = cmp[p] && (data_in[p] != exp_w[p]);
    end
  end

  // FSM: state register
  logic [2:0] drain_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state, sequenced by port A's phase
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (ram_en_a && ram_we_a)       state_nxt = S_WRITE;
                else if (ram_en_a)              state_nxt = S_READ;
      S_WRITE:  if (ram_en_a && !ram_we_a)      state_nxt = S_READ;
      S_READ:   if (!ram_en_a || ram_we_a)      state_nxt = S_DRAIN;
      S_DRAIN:  if (drain_cnt == 3'(RD_LATENCY - 1)) state_nxt = S_REPORT;
      S_REPORT: if (ram_en_a && ram_we_a)       state_nxt = S_WRITE;
                else if (ram_en_a)              state_nxt = S_READ;
                else                            state_nxt = S_IDLE;
      default:                                  state_nxt = S_IDLE;
    endcase
  end

  // FSM: state decodes
  logic in_drain, in_report, report_nxt;

  always_comb begin
    in_drain   = (state == S_DRAIN);
    in_report  = (state == S_REPORT);
    report_nxt = (state_nxt == S_REPORT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        drain_cnt <= '0;
    else if (in_drain) drain_cnt <= drain_cnt + 3'd1;
    else               drain_cnt <= '0;
  end

  // Round accounting; REPORT restarts the round but keeps its own cycle's comparisons.
  logic [7:0] rd_cnt [2];
  logic [7:0] rd_cnt_nxt [2];
  logic       round_fail, round_fail_nxt;

  always_comb begin
    round_fail_nxt = (in_report ? 1'b0 : round_fail) | (|mis);
    for (int p = 0; p < 2; p++) begin
      rd_cnt_nxt[p] = in_report ? 8'd0 : rd_cnt[p];
      if (cmp[p] && rd_cnt_nxt[p] != 8'hFF) rd_cnt_nxt[p] = rd_cnt_nxt[p] + 8'd1;
    end
  end

  logic [15:0] err_cnt [2];
  logic        first_seen;

  assign err_cnt_a = err_cnt[0];
  assign err_cnt_b = err_cnt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_done       <= 1'b0;
      round_ok       <= 1'b0;
      err_flag       <= 1'b0;
      err_cnt[0]     <= '0;
      err_cnt[1]     <= '0;
      round_cnt      <= '0;
      first_seen     <= 1'b0;
      first_err_port <= 1'b0;
      first_err_addr <= '0;
      first_err_data <= '0;
      rd_cnt[0]      <= '0;
      rd_cnt[1]      <= '0;
      round_fail     <= 1'b0;
    end else begin
      chk_done   <= report_nxt;
      round_fail <= round_fail_nxt;
      rd_cnt     <= rd_cnt_nxt;
      if (report_nxt) begin
        round_cnt <= round_cnt + 16'd1;
        round_ok  <= !round_fail_nxt
                     && rd_cnt_nxt[0] == 8'(READS_PER_ROUND)
                     && rd_cnt_nxt[1] == 8'(READS_PER_ROUND);
      end
      for (int p = 0; p < 2; p++)
        if (mis[p] && err_cnt[p] != 16'hFFFF) err_cnt[p] <= err_cnt[p] + 16'd1;
      if (|mis) err_flag <= 1'b1;
      // Port A takes priority when both ports fail in the same cycle.
      if (!first_seen && |mis) begin
        first_seen     <= 1'b1;
        first_err_port <= !mis[0];
        first_err_addr <= mis[0] ? adr[0][RD_LATENCY-1] : adr[1][RD_LATENCY-1];
        first_err_data <= mis[0] ? data_in[0] : data_in[1];
      end
    end
  end

endmodule

// File: tb/tb_ram_rd_check.sv
// Bench for ram_rd_check: two instances (read latency 1 and 2) share one stimulus
// stream; a round-level reference model predicts every chk_done and its outputs.
module tb_ram_rd_check;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       en_a, we_a, en_b, we_b;
  logic [4:0] addr_a, addr_b;
  logic [7:0] src_a, src_b;          // word the RAM model returns for this read

  logic       chk_done [2];
  logic       round_ok [2];
  logic       err_flag [2];
  logic [15:0] err_cnt_a [2];
  logic [15:0] err_cnt_b [2];
  logic [15:0] round_cnt [2];
  logic       first_err_port [2];
  logic [4:0] first_err_addr [2];
  logic [7:0] first_err_data [2];

  // RAM models: read data appears 1 or 2 cycles after the address
  logic [7:0] l1_a, l1_b;
  logic [7:0] l2_a [2];
  logic [7:0] l2_b [2];
  always @(posedge clk) begin
    l1_a    <= (en_a && !we_a) ? src_a : 8'h00;
    l1_b    <= (en_b && !we_b) ? src_b : 8'h00;
    l2_a[0] <= (en_a && !we_a) ? src_a : 8'h00;
    l2_b[0] <= (en_b && !we_b) ? src_b : 8'h00;
    l2_a[1] <= l2_a[0];
    l2_b[1] <= l2_b[0];
  end

  ram_rd_check #(.ADDR_W(5), .DATA_W(8), .RD_LATENCY(1), .READS_PER_ROUND(16)) dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .ram_en_a(en_a), .ram_en_b(en_b), .ram_we_a(we_a), .ram_we_b(we_b),
    .ram_addr_a(addr_a), .ram_addr_b(addr_b),
    .ram_rd_data_a(l1_a), .ram_rd_data_b(l1_b),
    .chk_done(chk_done[0]), .round_ok(round_ok[0]), .err_flag(err_flag[0]),
    .err_cnt_a(err_cnt_a[0]), .err_cnt_b(err_cnt_b[0]), .round_cnt(round_cnt[0]),
    .first_err_port(first_err_port[0]), .first_err_addr(first_err_addr[0]),
    .first_err_data(first_err_data[0])
  );

  ram_rd_check #(.ADDR_W(5), .DATA_W(8), .RD_LATENCY(2), .READS_PER_ROUND(16)) dut_l2 (
    .clk(clk), .rst_n(rst_n),
    .ram_en_a(en_a), .ram_en_b(en_b), .ram_we_a(we_a), .ram_we_b(we_b),
    .ram_addr_a(addr_a), .ram_addr_b(addr_b),
    .ram_rd_data_a(l2_a[1]), .ram_rd_data_b(l2_b[1]),
    .chk_done(chk_done[1]), .round_ok(round_ok[1]), .err_flag(err_flag[1]),
    .err_cnt_a(err_cnt_a[1]), .err_cnt_b(err_cnt_b[1]), .round_cnt(round_cnt[1]),
    .first_err_port(first_err_port[1]), .first_err_addr(first_err_addr[1]),
    .first_err_data(first_err_data[1])
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic string tg(input int k, input string s);
    return $sformatf("L%0d_%s", k + 1, s);
  endfunction

  // Reference model: cumulative results and the current round's tallies
  typedef struct {
    int          last_rd;
    logic        ok;
    logic [15:0] ea, eb, rc;
    logic        ef, fp;
    logic [4:0]  fa;
    logic [7:0]  fd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [15:0] m_ea, m_eb, m_rc;
  logic        m_ef, m_seen, m_fp;
  logic [4:0]  m_fa;
  logic [7:0]  m_fd;
  int          r_na, r_nb, last_rd;
  logic        r_fail;

  task automatic model_clear();
    m_ea = 0; m_eb = 0; m_rc = 0; m_ef = 0; m_seen = 0; m_fp = 0; m_fa = 0; m_fd = 0;
    r_na = 0; r_nb = 0; r_fail = 0; last_rd = 0;
  endtask

  task automatic model_read(input logic p, input logic [4:0] a, input logic [7:0] d);
    if (p) r_nb++; else r_na++;
    if (d != {3'b000, a}) begin
      r_fail = 1;
      m_ef   = 1;
      if (p) begin if (m_eb != 16'hFFFF) m_eb++; end
      else   begin if (m_ea != 16'hFFFF) m_ea++; end
      if (!m_seen) begin
        m_seen = 1; m_fp = p; m_fa = a; m_fd = d;
      end
    end
  endtask

  task automatic end_round();
    exp_t e;
    m_rc++;
    e.last_rd = last_rd;
    e.ok = !r_fail && r_na == 16 && r_nb == 16;
    e.ea = m_ea; e.eb = m_eb; e.rc = m_rc; e.ef = m_ef;
    e.fp = m_fp; e.fa = m_fa; e.fd = m_fd;
    q0.push_back(e);
    q1.push_back(e);
    r_na = 0; r_nb = 0; r_fail = 0;
  endtask

  // Monitors: every chk_done must match the next predicted round, at the predicted cycle
  task automatic on_done(input int k);
    exp_t e;
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      check(tg(k, "spurious_done"), 32'(chk_done[k]), 32'd0);
      return;
    end
    if (k == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    check(tg(k, "done_cycle"),     cyc,                      e.last_rd + k + 3);
    check(tg(k, "round_ok"),       32'(round_ok[k]),         32'(e.ok));
    check(tg(k, "err_cnt_a"),      32'(err_cnt_a[k]),        32'(e.ea));
    check(tg(k, "err_cnt_b"),      32'(err_cnt_b[k]),        32'(e.eb));
    check(tg(k, "round_cnt"),      32'(round_cnt[k]),        32'(e.rc));
    check(tg(k, "err_flag"),       32'(err_flag[k]),         32'(e.ef));
    check(tg(k, "first_err_port"), 32'(first_err_port[k]),   32'(e.fp));
    check(tg(k, "first_err_addr"), 32'(first_err_addr[k]),   32'(e.fa));
    check(tg(k, "first_err_data"), 32'(first_err_data[k]),   32'(e.fd));
  endtask

  always @(negedge clk) if (chk_done[0] === 1'b1) on_done(0);
  always @(negedge clk) if (chk_done[1] === 1'b1) on_done(1);

  task automatic check_zero(input int k);
    check(tg(k, "rst_chk_done"),  32'(chk_done[k]),       0);
    check(tg(k, "rst_round_ok"),  32'(round_ok[k]),       0);
    check(tg(k, "rst_err_flag"),  32'(err_flag[k]),       0);
    check(tg(k, "rst_err_cnt_a"), 32'(err_cnt_a[k]),      0);
    check(tg(k, "rst_err_cnt_b"), 32'(err_cnt_b[k]),      0);
    check(tg(k, "rst_round_cnt"), 32'(round_cnt[k]),      0);
    check(tg(k, "rst_fe_port"),   32'(first_err_port[k]), 0);
    check(tg(k, "rst_fe_addr"),   32'(first_err_addr[k]), 0);
    check(tg(k, "rst_fe_data"),   32'(first_err_data[k]), 0);
  endtask

  // One stimulus cycle, applied just after the rising edge
  task automatic drive(input logic ea, input logic wa, input logic [4:0] aa, input logic [7:0] da,
                       input logic eb, input logic wb, input logic [4:0] ab, input logic [7:0] db);
    @(posedge clk); #1;
    en_a = ea; we_a = wa; addr_a = aa; src_a = da;
    en_b = eb; we_b = wb; addr_b = ab; src_b = db;
    if (ea && !wa) begin model_read(1'b0, aa, da); last_rd = cyc; end
    if (eb && !wb) model_read(1'b1, ab, db);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 5'd0, 8'd0, 0, 0, 5'd0, 8'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    en_a = 0; we_a = 0; addr_a = 0; src_a = 0;
    en_b = 0; we_b = 0; addr_b = 0; src_b = 0;
    model_clear();
    q0.delete();
    q1.delete();
    #1;
    check_zero(0);
    check_zero(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic seg_end();
    idle(8);
    check("L1_missed_done", q0.size(), 0);
    check("L2_missed_done", q1.size(), 0);
  endtask

  // Read-phase addresses and the data the RAM returns for each
  logic [4:0] ra [16];
  logic [4:0] rb [16];
  logic [7:0] da [16];
  logic [7:0] db [16];

  task automatic set_clean();
    for (int i = 0; i < 16; i++) begin
      ra[i] = 5'(i);      da[i] = 8'(i);
      rb[i] = 5'(16 + i); db[i] = 8'(16 + i);
    end
  endtask

  task automatic set_random();
    for (int i = 0; i < 16; i++) begin
      ra[i] = 5'($urandom_range(0, 31));
      rb[i] = 5'($urandom_range(0, 31));
      da[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : {3'b000, ra[i]};
      db[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : {3'b000, rb[i]};
    end
  endtask

  task automatic write_phase();
    for (int i = 0; i < 16; i++) drive(1, 1, 5'(i), 8'd0, 1, 1, 5'(16 + i), 8'd0);
  endtask

  // Full round; b_skip leaves port B idle in that read slot (-1: none)
  task automatic run_round(input int b_skip);
    write_phase();
    for (int i = 0; i < 16; i++)
      drive(1, 0, ra[i], da[i], (i != b_skip), 0, rb[i], db[i]);
    end_round();
  endtask

  initial begin
    en_a = 0; we_a = 0; addr_a = 0; src_a = 0;
    en_b = 0; we_b = 0; addr_b = 0; src_b = 0;
    model_clear();
    do_reset();

    set_clean(); run_round(-1); seg_end();

    set_clean(); da[7] = 8'hA5; run_round(-1);
    set_clean(); run_round(-1); seg_end();

    do_reset();
    set_clean(); da[3] = 8'h5C; db[3] = 8'hE1; run_round(-1); seg_end();
    set_clean(); run_round(5); seg_end();

    do_reset();
    set_clean(); repeat (3) run_round(-1); seg_end();

    for (int r = 0; r < 6; r++) begin
      set_random();
      run_round(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1);
    end
    seg_end();

    set_clean();
    write_phase();
    for (int i = 0; i < 8; i++) drive(1, 0, ra[i], da[i], 1, 0, rb[i], db[i]);
    do_reset();
    set_clean(); run_round(-1); seg_end();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
